popcount_cfu_li2: RTL and testbench

- Parametrised, pipelined population-count CFU with a full request/response handshake (feature level 2).
- Generalises the combinational 32b popcount to any data width that is a multiple of 6 after zero-padding.
- Adds Hamming distance, masked popcount, parity and a running popcount accumulator.
- Sits on the CPU's CFU port; supports backpressure on both request and response.

---
 rtl/popcount_cfu_pkg.sv | 41 ++++
 rtl/popcount_cfu_li2_if.sv | 26 ++
 rtl/compress_6to3.sv | 11 +
 rtl/popcount_cfu_li2.sv | 144 ++++++++++++++
 tb/tb_popcount_cfu_li2.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/popcount_cfu_pkg.sv
// Shared function ids, decoded op encoding and width helpers for the popcount CFU.
package popcount_cfu_pkg;

    localparam int FN_POPC     = 0;
    localparam int FN_POPC_AND = 1;
    localparam int FN_HAMMING  = 2;
    localparam int FN_PARITY   = 3;
    localparam int FN_ACC      = 4;
    localparam int FN_ACC_CLR  = 5;

    typedef enum logic [2:0] {
        OP_POPC,
        OP_POPC_AND,
        OP_HAMMING,
        OP_PARITY,
        OP_ACC,
        OP_ACC_CLR,
        OP_ERR
    } op_e;

    function automatic int group_count(input int w);
        return (w + 5) / 6;
    endfunction

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic op_e decode_func(input logic [31:0] id);
        case (id)
            FN_POPC:     return OP_POPC;
            FN_POPC_AND: return OP_POPC_AND;
            FN_HAMMING:  return OP_HAMMING;
            FN_PARITY:   return OP_PARITY;
            FN_ACC:      return OP_ACC;
            FN_ACC_CLR:  return OP_ACC_CLR;
            default:     return OP_ERR;
        endcase
    endfunction

endpackage

// File: rtl/popcount_cfu_li2_if.sv
// CFU request/response port: valid/ready on both directions, CPU side is the master.
interface popcount_cfu_li2_if #(
    parameter int FUNC_ID_W   = 5,
    parameter int REQ_DATA_W  = 32,
    parameter int RESP_DATA_W = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic [FUNC_ID_W-1:0]   req_func_id;
    logic [REQ_DATA_W-1:0]  req_data0;
    logic [REQ_DATA_W-1:0]  req_data1;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [RESP_DATA_W-1:0] resp_data;
    logic                   resp_err;

    modport master (
        output req_valid, req_func_id, req_data0, req_data1, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_func_id, req_data0, req_data1, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/compress_6to3.sv
// 6:3 compressor: number of ones in a 6-bit slice.
// Purely combinational, no flow control.
module compress_6to3 (
    input  logic [5:0] bits,
    output logic [2:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 6; i++) cnt = cnt + {2'b00, bits[i]};
    end
endmodule

// File: rtl/popcount_cfu_li2.sv
// Pipelined popcount CFU (popc, and-popc, hamming, parity, accumulate); 3-cycle latency.
// All stages, bubbles included, hold while a response waits; req_ready = !resp_valid || resp_ready.
module popcount_cfu_li2
    import popcount_cfu_pkg::*;
#(
    parameter int CFU_FUNC_ID_W   = 5,
    parameter int CFU_REQ_DATA_W  = 32,
    parameter int CFU_RESP_DATA_W = 32,
    parameter int ACC_W           = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    popcount_cfu_li2_if.slave  cfu
);
    localparam int W  = CFU_REQ_DATA_W;
    localparam int NG = group_count(W);
    localparam int NC = group_count(NG);
    localparam int CW = cnt_w(W);

    logic                       advance;
    op_e                        dec_op, s0_op, s1_op, s2_op;
    logic                       s0_vld, s1_vld, s2_vld;
    logic [W-1:0]               opnd, s0_opnd;
    logic [NG*6-1:0]            padded;
    logic [2:0]                 grp_cnt [NG];
    logic [2:0]                 s1_cnt  [NG];
    logic [NC*6-1:0]            col_bits [3];
    logic [2:0]                 col_cnt  [3][NC];
    logic [CW-1:0]              col_sum  [3];
    logic [CW-1:0]              s2_col   [3];
    logic [CW-1:0]              count;
    logic [ACC_W-1:0]           acc, acc_nxt;
    logic [CFU_RESP_DATA_W-1:0] res, out_dat;
    logic                       err, out_err, out_vld;

    assign advance        = !out_vld || cfu.resp_ready;
    assign cfu.req_ready  = advance;
    assign cfu.resp_valid = out_vld;
    assign cfu.resp_data  = out_dat;
    assign cfu.resp_err   = out_err;

    assign dec_op = decode_func(32'(cfu.req_func_id));

    always_comb begin
        case (dec_op)
            OP_POPC_AND: opnd = cfu.req_data0 & cfu.req_data1;
            OP_HAMMING:  opnd = cfu.req_data0 ^ cfu.req_data1;
            default:     opnd = cfu.req_data0;
        endcase
    end

    always_comb begin
        padded         = '0;
        padded[W-1:0]  = s0_opnd;
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        compress_6to3 u_cmp (.bits(padded[6*g +: 6]), .cnt(grp_cnt[g]));
    end

    // Bit c of every group count has weight 2^c; gather each column and compress it again.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            col_bits[c] = '0;
            for (int g = 0; g < NG; g++) col_bits[c][g] = s1_cnt[g][c];
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_col
        for (genvar k = 0; k < NC; k++) begin : g_chunk
            compress_6to3 u_cmp (.bits(col_bits[c][6*k +: 6]), .cnt(col_cnt[c][k]));
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            col_sum[c] = '0;
            for (int k = 0; k < NC; k++) col_sum[c] = col_sum[c] + CW'(col_cnt[c][k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld  <= 1'b0;
            s0_op   <= OP_POPC;
            s0_opnd <= '0;
            s1_vld  <= 1'b0;
            s1_op   <= OP_POPC;
            s2_vld  <= 1'b0;
            s2_op   <= OP_POPC;
            for (int g = 0; g < NG; g++) s1_cnt[g] <= '0;
            for (int c = 0; c < 3; c++)  s2_col[c] <= '0;
        end else if (advance) begin
            s0_vld  <= cfu.req_valid;
            s0_op   <= dec_op;
            s0_opnd <= opnd;
            s1_vld  <= s0_vld;
            s1_op   <= s0_op;
            s1_cnt  <= grp_cnt;
            s2_vld  <= s1_vld;
            s2_op   <= s1_op;
            s2_col  <= col_sum;
        end
    end

    assign count = s2_col[0] + (s2_col[1] << 1) + (s2_col[2] << 2);

    always_comb begin
        res     = '0;
        err     = 1'b0;
        acc_nxt = acc;
        case (s2_op)
            OP_POPC, OP_POPC_AND, OP_HAMMING: res = CFU_RESP_DATA_W'(count);
            OP_PARITY: res = CFU_RESP_DATA_W'(count[0]);
            OP_ACC: begin
                acc_nxt = acc + ACC_W'(count);
                res     = CFU_RESP_DATA_W'(acc_nxt);
            end
            OP_ACC_CLR: begin
                res     = CFU_RESP_DATA_W'(acc);
                acc_nxt = '0;
            end
            default: err = 1'b1;
        endcase
    end

    // The accumulator only moves when its op lands in the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_err <= 1'b0;
            acc     <= '0;
        end else if (advance) begin
            out_vld <= s2_vld;
            if (s2_vld) begin
                out_dat <= res;
                out_err <= err;
                acc     <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_popcount_cfu_li2.sv
// Lockstep bench: a 32b/ACC_W=32 CFU and a 64b/ACC_W=8 CFU share one stimulus stream.
module tb_popcount_cfu_li2;
    import popcount_cfu_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc_t;
        bit          chk_lat;
        bit          seen;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [4:0]  func = '0;
    logic [63:0] a64 = '0;
    logic [63:0] b64 = '0;
    logic        ready = 1'b1;
    bit          lat_mode = 1'b0;
    bit          bp_done = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    exp_t            q      [2][$];
    logic [31:0]     log_d  [2][$];
    logic            log_e  [2][$];
    longint unsigned acc_m  [2];
    logic            held   [2];
    logic [31:0]     prev_d [2];
    logic            prev_e [2];

    int exp_p1 [7] = '{32, 0, 4, 32, 0, 1, 0};
    int exp_p2 [4] = '{8, 24, 24, 1};
    int exp_wa [9] = '{1, 32, 64, 96, 128, 160, 192, 224, 256};
    int exp_wb [9] = '{1, 32, 64, 96, 128, 160, 192, 224, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    popcount_cfu_li2_if #(.FUNC_ID_W(5), .REQ_DATA_W(32), .RESP_DATA_W(32)) bus_a ();
    popcount_cfu_li2_if #(.FUNC_ID_W(5), .REQ_DATA_W(64), .RESP_DATA_W(32)) bus_b ();

    popcount_cfu_li2 #(.CFU_FUNC_ID_W(5), .CFU_REQ_DATA_W(32), .CFU_RESP_DATA_W(32), .ACC_W(32))
        dut_a (.clk(clk), .rst_n(rst_n), .cfu(bus_a));
    popcount_cfu_li2 #(.CFU_FUNC_ID_W(5), .CFU_REQ_DATA_W(64), .CFU_RESP_DATA_W(32), .ACC_W(8))
        dut_b (.clk(clk), .rst_n(rst_n), .cfu(bus_b));

    assign bus_a.req_valid   = valid;
    assign bus_a.req_func_id = func;
    assign bus_a.req_data0   = a64[31:0];
    assign bus_a.req_data1   = b64[31:0];
    assign bus_a.resp_ready  = ready;
    assign bus_b.req_valid   = valid;
    assign bus_b.req_func_id = func;
    assign bus_b.req_data0   = a64;
    assign bus_b.req_data1   = b64;
    assign bus_b.resp_ready  = ready;

    logic        s_vld [2];
    logic        s_rdy [2];
    logic [31:0] s_dat [2];
    logic        s_err [2];
    assign s_vld[0] = bus_a.resp_valid;  assign s_vld[1] = bus_b.resp_valid;
    assign s_rdy[0] = bus_a.req_ready;   assign s_rdy[1] = bus_b.req_ready;
    assign s_dat[0] = bus_a.resp_data;   assign s_dat[1] = bus_b.resp_data;
    assign s_err[0] = bus_a.resp_err;    assign s_err[1] = bus_b.resp_err;

    // Reference: what one request returns, from the function table alone.
    task automatic predict(input int f, input logic [63:0] a, input logic [63:0] b, input int w,
                           input int accw, input longint unsigned acc_in,
                           output logic [31:0] d, output logic e, output longint unsigned acc_out);
        logic [63:0]     m;
        longint unsigned md;
        m       = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        md      = 64'd1 << accw;
        d       = '0;
        e       = 1'b0;
        acc_out = acc_in;
        case (f)
            FN_POPC:     d = 32'($countones(a & m));
            FN_POPC_AND: d = 32'($countones(a & b & m));
            FN_HAMMING:  d = 32'($countones((a ^ b) & m));
            FN_PARITY:   d = 32'($countones(a & m) % 2);
            FN_ACC: begin
                acc_out = (acc_in + longint'($countones(a & m))) % md;
                d       = 32'(acc_out);
            end
            FN_ACC_CLR: begin
                d       = 32'(acc_in);
                acc_out = 0;
            end
            default: e = 1'b1;
        endcase
    endtask

    always @(negedge clk) begin : cmp
        exp_t            e;
        logic [31:0]     pd;
        logic            pe;
        longint unsigned pa;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                q[d].delete();
                acc_m[d] = 0;
                held[d]  = 1'b0;
            end else begin
                checks++;
                if (s_rdy[d] !== (!s_vld[d] || ready)) begin
                    errors++;
                    $display("FAIL req_ready dut%0d @%0d: got %b required %b", d, cyc, s_rdy[d], !s_vld[d] || ready);
                end
                if (held[d]) begin
                    checks++;
                    if (s_vld[d] !== 1'b1 || s_dat[d] !== prev_d[d] || s_err[d] !== prev_e[d]) begin
                        errors++;
                        $display("FAIL hold dut%0d @%0d: got vld=%b data=%0d err=%b required vld=1 data=%0d err=%b",
                                 d, cyc, s_vld[d], s_dat[d], s_err[d], prev_d[d], prev_e[d]);
                    end
                end
                if (s_vld[d] === 1'b1) begin
                    checks++;
                    if (q[d].size() == 0) begin
                        errors++;
                        $display("FAIL spurious dut%0d @%0d: got resp_valid=1 data=%0d required no response", d, cyc, s_dat[d]);
                    end else begin
                        e = q[d][0];
                        if (s_dat[d] !== e.data || s_err[d] !== e.err) begin
                            errors++;
                            $display("FAIL resp dut%0d @%0d: got data=%0d err=%b required data=%0d err=%b",
                                     d, cyc, s_dat[d], s_err[d], e.data, e.err);
                        end
                        if (e.chk_lat && !e.seen) begin
                            checks++;
                            if (cyc - e.acc_t != 3) begin
                                errors++;
                                $display("FAIL latency dut%0d: got %0d cycles required 3", d, cyc - e.acc_t);
                            end
                        end
                        e.seen  = 1'b1;
                        q[d][0] = e;
                        if (ready) begin
                            log_d[d].push_back(s_dat[d]);
                            log_e[d].push_back(s_err[d]);
                            void'(q[d].pop_front());
                        end
                    end
                end
                held[d]   = s_vld[d] && !ready;
                prev_d[d] = s_dat[d];
                prev_e[d] = s_err[d];
                if (valid && s_rdy[d]) begin
                    predict(int'(func), a64, b64, (d == 0) ? 32 : 64, (d == 0) ? 32 : 8, acc_m[d], pd, pe, pa);
                    acc_m[d]  = pa;
                    e.data    = pd;
                    e.err     = pe;
                    e.acc_t   = cyc + 1;
                    e.chk_lat = lat_mode;
                    e.seen    = 1'b0;
                    q[d].push_back(e);
                end
            end
        end
    end

    task automatic send(input int f, input logic [63:0] a, input logic [63:0] b);
        int tries = 0;
        valid = 1'b1;
        func  = 5'(f);
        a64   = a;
        b64   = b;
        @(negedge clk);
        while (!s_rdy[0] && tries < 200) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got req_ready=0 for %0d cycles required acceptance", tries);
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        ready = 1'b1;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q[0].size() != 0 || q[1].size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d outstanding required 0", q[0].size(), q[1].size());
        end
        @(posedge clk); #1;
    endtask

    task automatic expect_log(input int d, input int idx, input int exp_d, input logic exp_e, input string name);
        checks++;
        if (idx >= log_d[d].size()) begin
            errors++;
            $display("FAIL %s dut%0d[%0d]: got no response required data=%0d", name, d, idx, exp_d);
        end else if (log_d[d][idx] !== 32'(exp_d) || log_e[d][idx] !== exp_e) begin
            errors++;
            $display("FAIL %s dut%0d[%0d]: got data=%0d err=%b required data=%0d err=%b",
                     name, d, idx, log_d[d][idx], log_e[d][idx], exp_d, exp_e);
        end
    endtask

    task automatic check_idle(input string name);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (s_vld[d] !== 1'b0 || s_dat[d] !== 32'd0 || s_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d: got vld=%b data=%0d err=%b required 0/0/0", name, d, s_vld[d], s_dat[d], s_err[d]);
            end
        end
    endtask

    task automatic pin(input string name, input int f, input logic [63:0] a, input logic [63:0] b, input int w,
                       input int accw, input longint unsigned acc_in, input logic [31:0] exp_d,
                       input logic exp_e, input longint unsigned exp_acc);
        logic [31:0]     d;
        logic            e;
        longint unsigned ao;
        predict(f, a, b, w, accw, acc_in, d, e, ao);
        checks++;
        if (d !== exp_d || e !== exp_e || ao != exp_acc) begin
            errors++;
            $display("FAIL %s: got data=%0d err=%b acc=%0d required data=%0d err=%b acc=%0d",
                     name, d, e, ao, exp_d, exp_e, exp_acc);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, b1;
        pin("pin_and",    FN_POPC_AND, 64'hFF00FF00, 64'h0FF00FF0, 32, 32, 0, 32'd8, 1'b0, 0);
        pin("pin_mask32", FN_POPC, 64'hFFFF_0000_0000_0001, 64'h0, 32, 32, 0, 32'd1, 1'b0, 0);
        pin("pin_wrap8",  FN_ACC, 64'hFFFFFFFF, 64'h0, 64, 8, 250, 32'd26, 1'b0, 26);
        pin("pin_clr",    FN_ACC_CLR, 64'h0, 64'h0, 32, 32, 77, 32'd77, 1'b0, 0);
        pin("pin_err",    9, 64'hFF, 64'h0, 32, 32, 5, 32'd0, 1'b1, 5);

        repeat (3) @(negedge clk);
        check_idle("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        lat_mode = 1'b1;
        b0 = log_d[0].size();
        b1 = log_d[1].size();
        send(FN_POPC,     64'hFFFFFFFF, 64'h0);
        send(FN_POPC,     64'h0,        64'h0);
        send(FN_POPC,     64'h80808080, 64'h0);
        send(FN_HAMMING,  64'hF0F0F0F0, 64'h0F0F0F0F);
        send(FN_POPC_AND, 64'hF0F0F0F0, 64'h0F0F0F0F);
        send(FN_PARITY,   64'h7,        64'h0);
        send(9,           64'h1234,     64'h0);
        drain();
        for (int i = 0; i < 7; i++) begin
            expect_log(0, b0 + i, exp_p1[i], i == 6, "func");
            expect_log(1, b1 + i, exp_p1[i], i == 6, "func");
        end

        b0 = log_d[0].size();
        b1 = log_d[1].size();
        send(FN_ACC,     64'hFF,   64'h0);
        send(FN_ACC,     64'hFFFF, 64'h0);
        send(FN_ACC_CLR, 64'h0,    64'h0);
        send(FN_ACC,     64'h1,    64'h0);
        drain();
        for (int i = 0; i < 4; i++) begin
            expect_log(0, b0 + i, exp_p2[i], 1'b0, "acc");
            expect_log(1, b1 + i, exp_p2[i], 1'b0, "acc");
        end

        b0 = log_d[0].size();
        b1 = log_d[1].size();
        send(FN_ACC_CLR, 64'h0, 64'h0);
        for (int i = 0; i < 8; i++) send(FN_ACC, 64'hFFFFFFFF, 64'h0);
        drain();
        for (int i = 0; i < 9; i++) begin
            expect_log(0, b0 + i, exp_wa[i], 1'b0, "wrap32");
            expect_log(1, b1 + i, exp_wb[i], 1'b0, "wrap8");
        end

        lat_mode = 1'b0;
        bp_done  = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send((i < 10) ? FN_POPC : int'($urandom_range(0, 9)),
                         {$urandom, $urandom}, {$urandom, $urandom});
                end
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        drain();

        lat_mode = 1'b1;
        send(FN_ACC_CLR, 64'h0,        64'h0);
        send(FN_ACC,     64'hFFFFFFFF, 64'h0);
        send(FN_ACC,     64'hFF,       64'h0);
        drain();
        send(FN_ACC, 64'h5, 64'h0);
        send(FN_ACC, 64'h7, 64'h0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset_midflight");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_idle("after_release");
        @(posedge clk); #1;
        b0 = log_d[0].size();
        b1 = log_d[1].size();
        send(FN_ACC,  64'h3, 64'h0);
        send(FN_POPC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        drain();
        expect_log(0, b0,     2,  1'b0, "acc_after_reset");
        expect_log(1, b1,     2,  1'b0, "acc_after_reset");
        expect_log(0, b0 + 1, 32, 1'b0, "popc_ones32");
        expect_log(1, b1 + 1, 64, 1'b0, "popc_ones64");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
